// File: rtl/synth_scaler.sv
// Volume scaler for the PWM path: shift, saturate to 10 bits, offset-binary,
// then a small FIFO so the sampler's request pulse always finds a code.
module synth_scaler #(
  parameter int IN_WIDTH   = 20,
  parameter int SHIFT_BASE = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          volume,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [9:0]          out_code,
  output logic [7:0]          underflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  localparam logic signed [IN_WIDTH-1:0] HI = IN_WIDTH'(511);
  localparam logic signed [IN_WIDTH-1:0] LO = IN_WIDTH'(-512);

  logic                       s1_v_q;
  logic signed [IN_WIDTH-1:0] s1_sh_q;
  logic                       s2_v_q;
  logic [9:0]                 s2_code_q;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [9:0]    last_q;
  logic [7:0]    uf_q;
  logic          rdy_q, rdy_d;

  logic                       acc, push, pop, empty;
  logic [5:0]                 shamt;
  logic signed [IN_WIDTH-1:0] sh_d;
  logic [9:0]                 clamp;
  logic [9:0]                 code_d;
  logic [CW-1:0]              total_d;

  assign acc   = in_valid && rdy_q;
  assign empty = (cnt_q == '0);
  assign push  = s2_v_q;
  assign pop   = !empty && out_ready;

  assign shamt = 6'(SHIFT_BASE) + {2'b00, volume};
  assign sh_d  = $signed(in_sample) >>> shamt;

  always_comb begin
    clamp = s1_sh_q[9:0];
    if (s1_sh_q > HI)
      clamp = 10'h1FF;
    else if (s1_sh_q < LO)
      clamp = 10'h200;
    code_d = {~clamp[9], clamp[8:0]};
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + 1'b1;
    else if (!push && pop)
      cnt_d = cnt_q - 1'b1;
  end

  // Credit counts in-flight samples so a FIFO slot is reserved per accept.
  assign total_d = CW'(cnt_d) + CW'(s1_v_q) + CW'(acc);
  assign rdy_d   = total_d < CW'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      last_q <= 10'd512;
      uf_q   <= '0;
      rdy_q  <= 1'b0;
    end else begin
      s1_v_q <= acc;
      s2_v_q <= s1_v_q;
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      if (push)
        wp_q <= wp_q + 1'b1;
      if (pop) begin
        rp_q   <= rp_q + 1'b1;
        last_q <= mem_q[rp_q];
      end
      if (out_ready && empty && uf_q != 8'hFF)
        uf_q <= uf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      s1_sh_q <= sh_d;
    if (s1_v_q)
      s2_code_q <= code_d;
    if (push)
      mem_q[wp_q] <= s2_code_q;
  end

  assign in_ready        = rdy_q;
  assign out_valid       = !empty;
  assign out_code        = empty ? last_q : mem_q[rp_q];
  assign underflow_count = uf_q;

endmodule

// File: doc/synth_scaler.md
Name: synth_scaler

Overview:
- Stage directly upstream of the PWM sampler.
- Accepts signed synthesizer samples via valid/ready, applies a volume-controlled arithmetic right shift, and saturates to signed 10 bits. Converts the result to the unsigned 10-bit offset-binary PWM code.
- Buffers codes in a small FIFO so the sampler's one-cycle ready pulse always finds a code waiting.
- Counts underflows, i.e. sampler requests that arrive when no code is available.

Parameters:
- IN_WIDTH, 20: width of the signed input sample.
- SHIFT_BASE, 7: right-shift applied at volume=0. Volume 3 maps full-scale input to full-scale code.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- volume  in  4  attenuation; total right shift = SHIFT_BASE+volume; sampled on input accept
- in_valid  in  1  in_sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_sample  in  IN_WIDTH  signed two's-complement sample
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sampler request; may be a single-cycle pulse
- out_code  out  10  unsigned PWM code, 512 = silence
- underflow_count  out  8  saturating count of requests made while empty

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. While rst is high:
  - FIFO empty, pipeline valids cleared, in-flight samples discarded.
  - out_valid=0, in_ready=0, out_code=512, underflow_count=0.
  - in_ready rises the cycle after rst deasserts.
- Input handshake:
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready = (fifo_count + stages_in_flight) < FIFO_DEPTH, registered or combinational from state only. It never depends on in_valid.
  - Overflow is impossible by construction.
- Pipeline (2 stages, fully pipelined, one sample per cycle):
  - S1: sh = in_sample >>> (SHIFT_BASE+volume), arithmetic (floor). Keep IN_WIDTH bits.
  - S2: clamp sh to [-512, 511]; code = clamped + 512, equivalently invert bit 9 of the clamped 10-bit value. Push code into the FIFO.
- Latency: a sample accepted at edge N is written to the FIFO at edge N+2. out_valid and the matching out_code are visible after edge N+2 (empty-FIFO case).
- Output handshake:
  - out_valid = !empty. When not empty, out_code = FIFO head (combinational).
  - A pop occurs on an edge with out_valid && out_ready. The popped code is copied into last_code.
  - When empty, out_code = last_code (holds the previous value, 512 after reset).
- Simultaneous push and pop on the same edge: allowed at any occupancy, including full (pop frees the slot) and empty (the pushed word is not bypassed; it appears the next cycle). Count is unchanged.
- Underflow: an edge with out_ready && !out_valid increments underflow_count, saturating at 255 with no wrap. No pop occurs.
- Volume change: takes effect only for samples accepted after the change. Samples in flight or buffered are unaffected.
- FIFO pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.

Test Plan:
- Reset, then volume=3 and single samples 0, 1024, -1024 -> codes 512, 513, 511. Each appears 2 edges after its accept; out_valid rises then.
- volume=0, in_sample=65536 -> 1023 (clamped); in_sample=-65537 -> 0 (clamped); volume=15, in_sample=-1 -> 511 (floor shift).
- Hold in_valid=1 with out_ready=0 -> exactly FIFO_DEPTH accepts, then in_ready=0. Pulse out_ready once -> one pop, then exactly one further accept. Codes emerge in order.
- Pulse out_ready 3 times on an empty FIFO after reset -> underflow_count=3 and out_code stays 512. Drive 300 such pulses -> count saturates at 255.
- FIFO full with in_valid and out_ready asserted on the same edge -> pop and push both occur, count stays FIFO_DEPTH, and no sample is lost or duplicated across a 16-sample ramp.
- Assert rst with 2 samples buffered and 1 in flight -> after release out_valid=0, out_code=512, underflow_count=0, and no stale code ever appears.
